prog_loader: RTL and testbench

- Boot-time program loader that sits directly upstream of the CPU's instruction memory. It replaces the simulation-only file preload with a real load path.
- Accepts a framed byte stream over a valid/ready handshake and assembles MSB-first 32-bit instruction words. Each word is written into instruction memory.
- Holds the CPU in reset until a complete frame with a correct checksum has been stored.

---
 rtl/loader_pkg.sv | 25 ++
 rtl/prog_loader_word_packer.sv | 68 ++++++
 rtl/prog_loader.sv | 171 +++++++++++++++++
 tb/tb_prog_loader.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and frame constants for the boot-time program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } ld_state_e;

  localparam int BYTE_W         = 8;
  localparam int LEN_BYTES      = 2;
  localparam int CSUM_BYTES     = 1;
  localparam int LEN_W          = LEN_BYTES * BYTE_W;
  localparam int DEFAULT_DATA_W = 32;
  localparam int BYTES_PER_WORD = DEFAULT_DATA_W / BYTE_W;

  function automatic int bytes_per_word(input int data_w);
    return data_w / BYTE_W;
  endfunction

endpackage

// File: rtl/prog_loader_word_packer.sv
// Assembles MSB-first bytes into DATA_W words; word/word_valid update the cycle after the final byte.
module word_packer
  import loader_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              accept,
  input  logic [7:0]        byte_in,
  output logic [DATA_W-1:0] word,
  output logic              word_valid,
  output logic              word_last
);

  localparam int BPW   = bytes_per_word(DATA_W);
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              word_valid_q, word_valid_d;

  assign word_last = (cnt_q == CNT_W'(BPW - 1));

  // Next-state for the byte counter, shift register and completed-word register.
  always_comb begin
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    if (clr) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (accept) begin
      shift_d = (shift_q << 8) | DATA_W'(byte_in);
      if (word_last) begin
        cnt_d        = '0;
        word_d       = shift_d;
        word_valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Packer state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      shift_q      <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign word       = word_q;
  assign word_valid = word_valid_q;

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: parses a length/payload/checksum byte frame into instruction
// memory writes and releases the CPU reset only after a verified frame.
module prog_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  localparam logic [LEN_W:0] MAX_WORDS = (LEN_W + 1)'(2 ** ADDR_W);

  ld_state_e         state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  word_idx_q, word_idx_d;
  logic [7:0]        csum_q, csum_d;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic              in_ready_q, in_ready_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              cpu_rst_q, cpu_rst_d;

  logic              accept_s;
  logic              pack_accept_s;
  logic              pack_clr_s;
  logic              word_last_s;
  logic [LEN_W-1:0]  len_s;

  assign accept_s = in_valid && in_ready_q;
  assign len_s    = {len_hi_q, in_data};

  word_packer #(.DATA_W(DATA_W)) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (pack_clr_s),
    .accept     (pack_accept_s),
    .byte_in    (in_data),
    .word       (im_wdata),
    .word_valid (im_we),
    .word_last  (word_last_s)
  );

  // Frame FSM: next state, counters, checksum and registered output values.
  always_comb begin
    state_d       = state_q;
    len_hi_d      = len_hi_q;
    len_d         = len_q;
    word_idx_d    = word_idx_q;
    csum_d        = csum_q;
    im_addr_d     = im_addr_q;
    pack_accept_s = 1'b0;
    pack_clr_s    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d    = ST_LEN_HI;
          csum_d     = 8'h00;
          word_idx_d = '0;
          pack_clr_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_LEN_HI: begin
        if (accept_s) begin
          len_hi_d = in_data;
          state_d  = ST_LEN_LO;
        end else begin
          state_d = state_q;
        end
      end
      ST_LEN_LO: begin
        if (accept_s) begin
          len_d = len_s;
          if (len_s == '0) begin
            state_d = ST_CSUM;
          end else if ({1'b0, len_s} > MAX_WORDS) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_DATA: begin
        // Leaving DATA at the final byte keeps a byte taken in the write cycle out of the payload.
        if (accept_s) begin
          pack_accept_s = 1'b1;
          csum_d        = csum_q ^ in_data;
          if (word_last_s) begin
            im_addr_d  = word_idx_q[ADDR_W-1:0];
            word_idx_d = word_idx_q + LEN_W'(1);
            if (word_idx_q == (len_q - LEN_W'(1))) begin
              state_d = ST_CSUM;
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_CSUM: begin
        if (accept_s) begin
          state_d = (in_data == csum_q) ? ST_DONE : ST_ERROR;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d = (state_d == ST_LEN_HI) || (state_d == ST_LEN_LO) ||
                 (state_d == ST_DATA)   || (state_d == ST_CSUM);
    done_d     = (state_d == ST_DONE);
    cpu_rst_d  = (state_d == ST_DONE);
    err_d      = (state_d == ST_ERROR);
  end

  // Loader state and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      len_hi_q   <= 8'h00;
      len_q      <= '0;
      word_idx_q <= '0;
      csum_q     <= 8'h00;
      im_addr_q  <= '0;
      in_ready_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cpu_rst_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_hi_q   <= len_hi_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      csum_q     <= csum_d;
      im_addr_q  <= im_addr_d;
      in_ready_q <= in_ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cpu_rst_q  <= cpu_rst_d;
    end
  end

  assign in_ready = in_ready_q;
  assign im_addr  = im_addr_q;
  assign done     = done_q;
  assign err      = err_q;
  assign cpu_rst  = cpu_rst_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader: frames, stalls, bad checksum, oversize length, reset.
module tb_prog_loader;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [DATA_W-1:0] im_wdata;
  logic              cpu_rst;
  logic              done;
  logic              err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [ADDR_W-1:0] wr_addr[$];
  logic [DATA_W-1:0] wr_data[$];

  prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .cpu_rst  (cpu_rst),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Write log: im_we is sampled mid-cycle, so each cycle of im_we adds one entry.
  always @(negedge clk) begin
    if (im_we) begin
      wr_addr.push_back(im_addr);
      wr_data.push_back(im_wdata);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check_eq("hs_timeout", 32'(n), 32'd0);
    tick();
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] bytes[$], input int gap);
    foreach (bytes[i]) begin
      send_byte(bytes[i]);
      if (gap > 0) repeat (gap) tick();
    end
  endtask

  task automatic check_nominal_writes(input string tag);
    check_eq({tag, "_wr_cnt"}, 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() >= 2) begin
      check_eq({tag, "_addr0"}, 32'(wr_addr[0]), 32'd0);
      check_eq({tag, "_data0"}, wr_data[0], 32'h1234_5678);
      check_eq({tag, "_addr1"}, 32'(wr_addr[1]), 32'd1);
      check_eq({tag, "_data1"}, wr_data[1], 32'h9ABC_DEF0);
    end else begin
      check_eq({tag, "_writes_present"}, 32'(wr_addr.size()), 32'd2);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check_eq({tag, "_im_we"},    32'(im_we),    32'd0);
    check_eq({tag, "_im_addr"},  32'(im_addr),  32'd0);
    check_eq({tag, "_im_wdata"}, im_wdata,      32'd0);
    check_eq({tag, "_cpu_rst"},  32'(cpu_rst),  32'd0);
    check_eq({tag, "_done"},     32'(done),     32'd0);
    check_eq({tag, "_err"},      32'(err),      32'd0);
  endtask

  logic [7:0] nominal[$] = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
                              8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00};
  logic [7:0] bad_csum[$] = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
                               8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h01};
  logic [7:0] empty[$]    = '{8'h00, 8'h00, 8'h00};
  logic [7:0] oversize[$] = '{8'h04, 8'h01};
  logic [7:0] maxlen[$]   = '{8'h04, 8'h00};
  logic [7:0] partial[$]  = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56};

  initial begin
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b1;
    tick();

    // Nominal load; idle input with no start must leave in_ready low.
    check_eq("idle_in_ready", 32'(in_ready), 32'd0);
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    check_eq("start_in_ready", 32'(in_ready), 32'd1);
    check_eq("start_cpu_rst", 32'(cpu_rst), 32'd0);
    send_frame(nominal, 0);
    check_eq("nom_done", 32'(done), 32'd1);
    check_eq("nom_cpu_rst", 32'(cpu_rst), 32'd1);
    check_eq("nom_err", 32'(err), 32'd0);
    check_eq("nom_in_ready", 32'(in_ready), 32'd0);
    repeat (2) tick();
    check_nominal_writes("nom");
    check_eq("nom_hold_addr", 32'(im_addr), 32'd1);
    check_eq("nom_hold_wdata", im_wdata, 32'h9ABC_DEF0);
    check_eq("nom_done_held", 32'(done), 32'd1);

    // Bad checksum, started from DONE.
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    check_eq("restart_done_clr", 32'(done), 32'd0);
    check_eq("restart_cpu_rst_clr", 32'(cpu_rst), 32'd0);
    send_frame(bad_csum, 0);
    check_eq("bad_err", 32'(err), 32'd1);
    check_eq("bad_done", 32'(done), 32'd0);
    check_eq("bad_cpu_rst", 32'(cpu_rst), 32'd0);
    check_eq("bad_in_ready", 32'(in_ready), 32'd0);
    repeat (2) tick();
    check_nominal_writes("bad");

    // Empty program, started from ERROR.
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    check_eq("restart_err_clr", 32'(err), 32'd0);
    send_frame(empty, 0);
    check_eq("empty_done", 32'(done), 32'd1);
    check_eq("empty_cpu_rst", 32'(cpu_rst), 32'd1);
    repeat (2) tick();
    check_eq("empty_wr_cnt", 32'(wr_addr.size()), 32'd0);

    // Stalls of three cycles between every byte.
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_frame(nominal, 3);
    check_eq("stall_done", 32'(done), 32'd1);
    check_eq("stall_err", 32'(err), 32'd0);
    check_nominal_writes("stall");

    // Oversize length: 0x0401 words exceeds 1024.
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_frame(oversize, 0);
    check_eq("over_err", 32'(err), 32'd1);
    check_eq("over_in_ready", 32'(in_ready), 32'd0);
    check_eq("over_cpu_rst", 32'(cpu_rst), 32'd0);
    repeat (3) tick();
    check_eq("over_wr_cnt", 32'(wr_addr.size()), 32'd0);

    // Exactly 1024 words is legal; start is ignored mid-load.
    pulse_start();
    send_frame(maxlen, 0);
    check_eq("max_err", 32'(err), 32'd0);
    check_eq("max_in_ready", 32'(in_ready), 32'd1);
    pulse_start();
    check_eq("max_start_ignored", 32'(in_ready), 32'd1);

    // Reset mid-load after five bytes of the nominal frame.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_frame(partial, 0);
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (3) tick();
    check_eq("midrst_wr_cnt", 32'(wr_addr.size()), 32'd0);
    rst = 1'b1;
    tick();
    pulse_start();
    send_frame(nominal, 0);
    check_eq("after_rst_done", 32'(done), 32'd1);
    check_eq("after_rst_cpu_rst", 32'(cpu_rst), 32'd1);
    repeat (2) tick();
    check_nominal_writes("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
